// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC sweep sequencer.
// Holds the scan state encoding, the park code written when a scan ends
// (mid-scale, roughly 0 V at the DAC output) and the channel select values.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        PARK = 2'd3
    } seq_state_t;

    localparam logic [13:0] PARK_CODE = 14'h2000;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler for the sweep.
// Counts 0..div and raises tick in the cycle where count == div, then wraps,
// so a tick occurs every div+1 cycles (div = 0 gives a tick every cycle).
// While clear is high the count is held at 0 and no tick is produced.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clear - hold the counter at zero (no ticks)
//   div   - tick period minus one, in clk cycles
//   tick  - high for one cycle per period
module tick_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;

    assign tick = !clear && (count == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || count == div) begin
            count <= '0;
        end else begin
            count <= count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dac_sweep_sequencer.sv
// Sequencer for the shared two-channel DAC write port.
// Generates a triangular scan on channel A between a latched min and max code,
// stepping once per prescaler tick, and arbitrates the scan against direct PS
// writes so that at most one DAC write is issued per cycle. A scan ends
// (after the requested number of up/down periods, or on stop) by writing
// PARK_CODE to channel A.
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   start_i, stop_i   - single-cycle scan start / abort pulses
//   cfg_min_i/max_i   - scan lower / upper code
//   cfg_step_i        - code increment per tick
//   cfg_div_i         - tick period minus one, in clk cycles
//   cfg_cycles_i      - number of full up/down periods, 0 = continuous
//   ps_wr_i/sel_i/dat_i - PS direct write request, channel and code
//   dac_dat_o/sel_o/wrt_o - registered DAC write port
//   busy_o            - scan active (UP/DOWN/PARK)
//   done_o            - pulse when the park write issues
//   err_o             - pulse when start_i carries an invalid config
//   ps_blocked_o      - pulse when a PS write is dropped
//   state_o           - IDLE=0, UP=1, DOWN=2, PARK=3
module dac_sweep_sequencer
    import dac_seq_pkg::seq_state_t, dac_seq_pkg::IDLE, dac_seq_pkg::UP,
           dac_seq_pkg::DOWN, dac_seq_pkg::PARK, dac_seq_pkg::CH_A,
           dac_seq_pkg::CH_B;
#(
    parameter int                        DAC_DATA_WIDTH = 14,
    parameter int                        DIV_WIDTH      = 16,
    parameter logic [DAC_DATA_WIDTH-1:0] PARK_CODE      = dac_seq_pkg::PARK_CODE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_min_i,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_max_i,
    input  logic [DAC_DATA_WIDTH-1:0] cfg_step_i,
    input  logic [DIV_WIDTH-1:0]      cfg_div_i,
    input  logic [7:0]                cfg_cycles_i,
    input  logic                      ps_wr_i,
    input  logic                      ps_sel_i,
    input  logic [DAC_DATA_WIDTH-1:0] ps_dat_i,
    output logic [DAC_DATA_WIDTH-1:0] dac_dat_o,
    output logic                      dac_sel_o,
    output logic                      dac_wrt_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      ps_blocked_o,
    output logic [1:0]                state_o
);

    localparam int W = DAC_DATA_WIDTH;

    seq_state_t     state, next_state;
    logic [W-1:0]   code, next_code;
    logic [W-1:0]   min_r, max_r, step_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic [7:0]     cycles_r, cyc_cnt, next_cnt;

    logic           pend_valid;
    logic [W-1:0]   pend_code;

    logic           tick, presc_clear;
    logic           cfg_valid, start_ok, start_err, flush;
    logic           sw_req;
    logic [W-1:0]   sw_code;
    logic [W:0]     up_sum, down_limit;

    logic           ps_grant, ps_drop;
    logic           cand_valid, park_req, park_issue;
    logic [W-1:0]   cand_code;

    assign cfg_valid   = (cfg_min_i < cfg_max_i) && (cfg_step_i != '0);
    assign start_ok    = (state == IDLE) && start_i && cfg_valid;

    // One extra bit so code+step and min+step can never wrap.
    assign up_sum      = {1'b0, code} + {1'b0, step_r};
    assign down_limit  = {1'b0, min_r} + {1'b0, step_r};

    // The prescaler only runs during the ramp; it is held at zero in IDLE so
    // the first tick lands div+1 cycles after the initial min write request.
    assign presc_clear = (state != UP) && (state != DOWN);

    tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (presc_clear),
        .div   (div_r),
        .tick  (tick)
    );

    // Arbitration. A granted PS write always wins the port; a sweep write
    // that loses is parked in the 1-deep pending slot (a newer sweep code
    // overwrites it). The park write never goes into the pending slot: PARK
    // simply keeps requesting until the port is free and nothing is pending.
    assign ps_grant   = ps_wr_i && ((ps_sel_i == CH_B) || (state == IDLE));
    assign ps_drop    = ps_wr_i && !ps_grant;
    assign cand_valid = !flush && (sw_req || pend_valid);
    assign cand_code  = sw_req ? sw_code : pend_code;
    assign park_req   = (state == PARK) && !pend_valid;
    assign park_issue = park_req && !ps_grant;

    always_comb begin
        next_state = state;
        next_code  = code;
        next_cnt   = cyc_cnt;
        sw_req     = 1'b0;
        sw_code    = code;
        start_err  = 1'b0;
        flush      = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    if (cfg_valid) begin
                        next_state = UP;
                        next_code  = cfg_min_i;
                        next_cnt   = '0;
                        sw_req     = 1'b1;
                        sw_code    = cfg_min_i;
                    end else begin
                        start_err  = 1'b1;
                    end
                end
            end

            UP: begin
                if (stop_i) begin
                    next_state = PARK;
                    flush      = 1'b1;
                end else if (tick) begin
                    if (up_sum >= {1'b0, max_r}) begin
                        next_code  = max_r;
                        next_state = DOWN;
                    end else begin
                        next_code  = up_sum[W-1:0];
                    end
                    sw_req  = 1'b1;
                    sw_code = next_code;
                end
            end

            DOWN: begin
                if (stop_i) begin
                    next_state = PARK;
                    flush      = 1'b1;
                end else if (tick) begin
                    if ({1'b0, code} <= down_limit) begin
                        next_code = min_r;
                        next_cnt  = cyc_cnt + 8'd1;
                        if (cycles_r != 8'd0 && next_cnt == cycles_r) begin
                            next_state = PARK;
                        end else begin
                            next_state = UP;
                        end
                    end else begin
                        next_code = code - step_r;
                    end
                    sw_req  = 1'b1;
                    sw_code = next_code;
                end
            end

            PARK: begin
                if (park_issue) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            code         <= '0;
            cyc_cnt      <= '0;
            min_r        <= '0;
            max_r        <= '0;
            step_r       <= '0;
            div_r        <= '0;
            cycles_r     <= '0;
            pend_valid   <= 1'b0;
            pend_code    <= '0;
            dac_dat_o    <= PARK_CODE;
            dac_sel_o    <= CH_A;
            dac_wrt_o    <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            ps_blocked_o <= 1'b0;
        end else begin
            state        <= next_state;
            code         <= next_code;
            cyc_cnt      <= next_cnt;
            done_o       <= park_issue;
            err_o        <= start_err;
            ps_blocked_o <= ps_drop;
            dac_wrt_o    <= 1'b0;

            if (start_ok) begin
                min_r    <= cfg_min_i;
                max_r    <= cfg_max_i;
                step_r   <= cfg_step_i;
                div_r    <= cfg_div_i;
                cycles_r <= cfg_cycles_i;
            end

            if (ps_grant) begin
                dac_dat_o  <= ps_dat_i;
                dac_sel_o  <= ps_sel_i;
                dac_wrt_o  <= 1'b1;
                pend_valid <= cand_valid;
                if (cand_valid) begin
                    pend_code <= cand_code;
                end
            end else if (cand_valid) begin
                dac_dat_o  <= cand_code;
                dac_sel_o  <= CH_A;
                dac_wrt_o  <= 1'b1;
                pend_valid <= 1'b0;
            end else begin
                pend_valid <= 1'b0;
                if (park_req) begin
                    dac_dat_o <= PARK_CODE;
                    dac_sel_o <= CH_A;
                    dac_wrt_o <= 1'b1;
                end
            end
        end
    end

    assign busy_o  = (state != IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Self-checking bench for dac_sweep_sequencer.
// The reference model builds the list of scan codes with clamped arithmetic,
// schedules one sweep write request every div+1 cycles from the start cycle,
// and resolves each cycle's requests with the PS-first / pending-slot rule.
module tb_dac_sweep_sequencer;

    logic        clk;
    logic        rst;
    logic        start_i, stop_i;
    logic [13:0] cfg_min_i, cfg_max_i, cfg_step_i;
    logic [15:0] cfg_div_i;
    logic [7:0]  cfg_cycles_i;
    logic        ps_wr_i, ps_sel_i;
    logic [13:0] ps_dat_i;
    logic [13:0] dac_dat_o;
    logic        dac_sel_o, dac_wrt_o, busy_o, done_o, err_o, ps_blocked_o;
    logic [1:0]  state_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_codes[$];

    dac_sweep_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .cfg_min_i    (cfg_min_i),
        .cfg_max_i    (cfg_max_i),
        .cfg_step_i   (cfg_step_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_cycles_i (cfg_cycles_i),
        .ps_wr_i      (ps_wr_i),
        .ps_sel_i     (ps_sel_i),
        .ps_dat_i     (ps_dat_i),
        .dac_dat_o    (dac_dat_o),
        .dac_sel_o    (dac_sel_o),
        .dac_wrt_o    (dac_wrt_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .ps_blocked_o (ps_blocked_o),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic wr,
                                 input logic sel, input logic [13:0] dat);
        start_i  = start;
        stop_i   = stop;
        ps_wr_i  = wr;
        ps_sel_i = sel;
        ps_dat_i = dat;
    endtask

    // Scan codes: up from min in steps clamped at max, down clamped at min.
    function automatic void buildCodes(input int mn, input int mx, input int st, input int cy);
        int c;
        exp_codes.delete();
        c = mn;
        exp_codes.push_back(c);
        for (int p = 0; p < cy; p++) begin
            while (c < mx) begin
                c = (c + st >= mx) ? mx : c + st;
                exp_codes.push_back(c);
            end
            while (c > mn) begin
                c = (c - st <= mn) ? mn : c - st;
                exp_codes.push_back(c);
            end
        end
    endfunction

    // Runs one complete scan from IDLE, checking every cycle until the park
    // write. stop_at < 0 means no abort; force_t >= 0 injects a PS write.
    task automatic runScan(input int mn, input int mx, input int st, input int dv,
                           input int cy, input int ps_pct, input int stop_at,
                           input int force_t, input logic force_sel,
                           input logic [13:0] force_dat);
        int          n, per, last_t, budget, t;
        bit          pend_v, ended, new_v, cand_v, grant, park_phase, stopped_now;
        int          pend_c, new_c, cand_c;
        logic        ps_w, ps_s;
        logic [13:0] ps_d;
        logic        e_wrt, e_sel, e_done, e_blk, e_busy;
        logic [13:0] e_dat;

        buildCodes(mn, mx, st, cy);
        n      = exp_codes.size();
        per    = dv + 1;
        last_t = (n - 1) * per;
        budget = last_t + 200;

        cfg_min_i    = 14'(mn);
        cfg_max_i    = 14'(mx);
        cfg_step_i   = 14'(st);
        cfg_div_i    = 16'(dv);
        cfg_cycles_i = 8'(cy);

        pend_v = 0;
        pend_c = 0;
        ended  = 0;
        t      = 0;
        while (!ended && t < budget) begin
            ps_w = 1'b0;
            ps_s = 1'b0;
            ps_d = '0;
            if (t == force_t) begin
                ps_w = 1'b1;
                ps_s = force_sel;
                ps_d = force_dat;
            end else if (ps_pct > 0 && $urandom_range(0, 99) < ps_pct) begin
                ps_w = 1'b1;
                ps_s = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                ps_d = 14'($urandom_range(0, 16383));
            end
            applyStimulus(t == 0, t == stop_at, ps_w, ps_s, ps_d);
            if (t == 1) begin
                cfg_min_i    = 14'($urandom);
                cfg_max_i    = 14'($urandom);
                cfg_step_i   = 14'($urandom);
                cfg_div_i    = 16'($urandom_range(0, 7));
                cfg_cycles_i = 8'($urandom);
            end

            stopped_now = (t == stop_at);
            park_phase  = (stop_at >= 0) ? (t > stop_at) : (t > last_t);
            new_v = !park_phase && !stopped_now && (t % per == 0) && (t / per < n);
            new_c = 0;
            if (new_v) new_c = exp_codes[t / per];
            if (stopped_now) pend_v = 0;
            grant  = ps_w && (ps_s == 1'b1 || t == 0);
            cand_v = new_v || pend_v;
            cand_c = new_v ? new_c : pend_c;

            e_wrt  = 1'b0;
            e_dat  = '0;
            e_sel  = 1'b0;
            e_done = 1'b0;
            if (grant) begin
                e_wrt  = 1'b1;
                e_dat  = ps_d;
                e_sel  = ps_s;
                pend_v = cand_v;
                pend_c = cand_c;
            end else if (cand_v) begin
                e_wrt  = 1'b1;
                e_dat  = 14'(cand_c);
                pend_v = 0;
            end else if (park_phase) begin
                e_wrt  = 1'b1;
                e_dat  = 14'h2000;
                e_done = 1'b1;
                ended  = 1;
            end
            e_blk  = ps_w && !grant;
            e_busy = !ended;

            @(negedge clk);
            checkOutput("dac_wrt", dac_wrt_o, e_wrt);
            if (e_wrt) begin
                checkOutput("dac_dat", dac_dat_o, e_dat);
                checkOutput("dac_sel", dac_sel_o, e_sel);
            end
            checkOutput("done", done_o, e_done);
            checkOutput("ps_blocked", ps_blocked_o, e_blk);
            checkOutput("busy", busy_o, e_busy);
            t++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        if (!ended) checkOutput("scan_timeout", 0, 1);
        checkOutput("state_after_scan", state_o, 0);
        @(negedge clk);
        checkOutput("done_once", done_o, 0);
    endtask

    initial begin
        int mn, mx;
        bit found;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cfg_min_i    = '0;
        cfg_max_i    = '0;
        cfg_step_i   = '0;
        cfg_div_i    = '0;
        cfg_cycles_i = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_dac_dat", dac_dat_o, 14'h2000);
        checkOutput("rst_dac_sel", dac_sel_o, 0);
        checkOutput("rst_dac_wrt", dac_wrt_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_blocked", ps_blocked_o, 0);
        checkOutput("rst_state", state_o, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_wrt", dac_wrt_o, 0);

        // basic scan and clamped scan with spaced ticks
        runScan(100, 130, 10, 0, 1, 0, -1, -1, 1'b0, '0);
        runScan(0, 25, 10, 3, 1, 0, -1, -1, 1'b0, '0);
        // PS channel-B write colliding with a tick
        runScan(100, 130, 10, 2, 1, 0, -1, 3, 1'b1, 14'h1234);
        // PS channel-A write during UP is dropped
        runScan(100, 130, 10, 0, 1, 0, -1, 2, 1'b0, 14'h1234);

        // the same channel-A request in IDLE is granted
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 14'h1234);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("idle_psA_wrt", dac_wrt_o, 1);
        checkOutput("idle_psA_dat", dac_dat_o, 14'h1234);
        checkOutput("idle_psA_sel", dac_sel_o, 0);
        checkOutput("idle_psA_blocked", ps_blocked_o, 0);

        // abort mid-UP
        runScan(0, 1000, 10, 1, 1, 0, 7, -1, 1'b0, '0);

        // invalid configs: min >= max, then step == 0
        cfg_min_i  = 14'd200;
        cfg_max_i  = 14'd100;
        cfg_step_i = 14'd10;
        cfg_div_i  = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("inv_err", err_o, 1);
        checkOutput("inv_state", state_o, 0);
        checkOutput("inv_wrt", dac_wrt_o, 0);
        @(negedge clk);
        checkOutput("inv_err_pulse", err_o, 0);
        checkOutput("inv_state2", state_o, 0);
        cfg_min_i  = 14'd100;
        cfg_max_i  = 14'd200;
        cfg_step_i = 14'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("inv_step_err", err_o, 1);
        checkOutput("inv_step_busy", busy_o, 0);

        // top-of-range scan (15-bit sum) and step larger than the span
        runScan(16300, 16383, 50, 1, 1, 0, -1, -1, 1'b0, '0);
        runScan(0, 25, 100, 0, 1, 0, -1, -1, 1'b0, '0);

        // randomized scans with random PS traffic
        for (int i = 0; i < 6; i++) begin
            mn = $urandom_range(0, 8000);
            mx = mn + $urandom_range(1, 60);
            runScan(mn, mx, $urandom_range(1, 25), $urandom_range(0, 3),
                    $urandom_range(1, 2), 30, -1, -1, 1'b0, '0);
        end

        // asynchronous reset while in DOWN of a continuous scan
        cfg_min_i    = 14'd100;
        cfg_max_i    = 14'd130;
        cfg_step_i   = 14'd10;
        cfg_div_i    = 16'd0;
        cfg_cycles_i = 8'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (state_o == 2'd2) found = 1;
        end
        checkOutput("reach_down", found, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_dat", dac_dat_o, 14'h2000);
        checkOutput("async_rst_wrt", dac_wrt_o, 0);
        checkOutput("async_rst_busy", busy_o, 0);
        checkOutput("async_rst_state", state_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("post_rst_no_wrt", dac_wrt_o, 0);
        end
        checkOutput("post_rst_state", state_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
